seg_digit_scanner: RTL and testbench
====================================

Name: seg_digit_scanner

Overview:
Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a captured hex value and selects one 4-bit nibble per scan slot, which feeds the hex-to-7-segment decoder. It drives the matching active-low digit enable, with inter-digit dead time against ghosting and optional leading-zero blanking. It sits directly upstream of the segment decoder. The decoder's seg_out and this block's digit_an go to the pins together.

Parameters:
NUM_DIGITS, 4, number of display digits; legal range 2..8
SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2
DEAD_CYC, 16, cycles at the start of each slot with all anodes off; must be < SCAN_DIV; 0 disables dead time

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
load  input  1  capture value_in into the shadow register on this clk edge
value_in  input  4*NUM_DIGITS  hex value; nibble i (bits 4i+3:4i) is digit i, and digit 0 is rightmost
blank_lz  input  1  1 = blank leading zero digits
data_out  output  4  nibble for the current digit, to the decoder's data_in
digit_an  output  NUM_DIGITS  active-low digit enables; bit i drives digit i
digit_idx  output  clog2(NUM_DIGITS)  index of the current slot

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- State registers:
  - shadow (4*NUM_DIGITS bits)
  - tick (counter, 0..SCAN_DIV-1)
  - idx (0..NUM_DIGITS-1)
- All outputs are combinational functions of these registers only. No input reaches an output combinationally.
- Reset: shadow=0, tick=0, idx=0. With DEAD_CYC>0 this gives data_out=0, digit_idx=0 and digit_an all ones. With DEAD_CYC=0, digit_an has bit 0 low.
- Reset mid-scan: the state is abandoned and the reset values apply on the next cycle.
- Shadow register:
  - load=1 at an edge sets shadow <= value_in.
  - The new value is visible on data_out the following cycle.
  - load is level-sampled every cycle; holding it high tracks value_in.
- Prescaler:
  - tick increments each cycle.
  - When tick==SCAN_DIV-1, tick wraps to 0 and idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
- data_out = shadow[4*idx +: 4] at all times, including dead time and blanked slots.
- digit_idx = idx.
- Leading-zero blanking: digit i is blanked iff all of the following hold:
  - blank_lz=1
  - i != 0
  - nibbles NUM_DIGITS-1 down to i are all zero
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
- digit_an:
  - All ones when tick < DEAD_CYC, or when digit idx is blanked.
  - Otherwise only bit idx is low.
  - At most one bit is low in any cycle.
- Simultaneous load and slot wrap: both take effect on the same edge. The new slot shows the new shadow's nibble and its blanking status.
- blank_lz changes: they take effect in the next cycle's digit_an, because blank_lz is registered into a 1-bit flop together with shadow on every edge. It is not gated by load.
- Full scan period = NUM_DIGITS*SCAN_DIV cycles. Each digit is lit for SCAN_DIV-DEAD_CYC cycles per period.

Test Plan:
(All use NUM_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2.)
1. Reset: assert rst 3 cycles, then release → data_out=0, digit_idx=0, digit_an=4'b1111 for 2 cycles, then 4'b1110 for 6 cycles, then idx=1 with 4'b1111.
2. Scan order: load=1 for one cycle with value_in=16'h1A3F, blank_lz=0 → data_out sequence per slot is F,3,A,1,F. digit_an lit values are 1110, 1101, 1011, 0111. Each is preceded by 2 cycles of 1111, and the pattern repeats every 32 cycles.
3. Leading-zero blanking: value 16'h0050 with blank_lz=1 → slots 3 and 2 hold digit_an=4'b1111 for all 8 cycles. Slot 1 lights 1101 with data_out=5, and slot 0 lights 1110 with data_out=0. Value 16'h0000 → only digit 0 is lit. Value 16'h0000 with blank_lz=0 → all four digits are lit with data_out=0.
4. Load at wrap: load 16'h2222 in the cycle where tick=7, idx=0 → the next cycle has idx=1, tick=0, data_out=2. No slot shows the stale value.
5. Reset mid-scan: assert rst at idx=2, tick=5 → the next cycle has idx=0, tick=0, shadow=0 and digit_an=4'b1111.
6. DEAD_CYC=0 build: after reset, digit_an=4'b1110 immediately. A slot change at the wrap edge switches the low bit directly, e.g. 1110 to 1101, with no all-ones cycle and never two bits low.

Source files
------------

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner: time-multiplexed 7-segment scan controller with per-slot dead time
// and optional leading-zero blanking; drives the nibble and active-low anode for each slot.
module seg_digit_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [4*NUM_DIGITS-1:0]         value_in,
    input  logic                            blank_lz,
    output logic [3:0]                      data_out,
    output logic [NUM_DIGITS-1:0]           digit_an,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int TW = $clog2(SCAN_DIV);

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    blank_q;
    logic                    wrap;
    logic                    run;
    logic [NUM_DIGITS-1:0]   lz;

    always_comb begin
        wrap     = tick_q == TW'(SCAN_DIV - 1);
        tick_d   = wrap ? '0 : tick_q + 1'b1;
        idx_d    = !wrap ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        shadow_d = load ? value_in : shadow_q;
    end

    // lz[i] is set when every nibble from the top down to i is zero
    always_comb begin
        run = 1'b1;
        lz  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run   = run && (shadow_q[4*i +: 4] == 4'h0);
            lz[i] = run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            tick_q   <= '0;
            idx_q    <= '0;
            blank_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            blank_q  <= blank_lz;
        end
    end

    assign data_out  = shadow_q[4*idx_q +: 4];
    assign digit_idx = idx_q;
    assign digit_an  = (int'(tick_q) < DEAD_CYC || (blank_q && idx_q != '0 && lz[idx_q]))
                       ? '1 : ~(NUM_DIGITS'(1) << idx_q);
endmodule

// File: tb/tb_seg_digit_scanner.sv
// tb_seg_digit_scanner: directed checks of scan order, dead time, blanking, load timing and reset,
// on a DEAD_CYC=2 build and a DEAD_CYC=0 build sharing the same stimulus.
module tb_seg_digit_scanner;
    logic        clk, rst, load, blank_lz;
    logic [15:0] value_in;
    logic [3:0]  data_out, digit_an, data_out0, digit_an0;
    logic [1:0]  digit_idx, digit_idx0;
    int          checks = 0;
    int          errors = 0;

    seg_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_lz(blank_lz),
        .data_out(data_out), .digit_an(digit_an), .digit_idx(digit_idx));

    seg_digit_scanner #(.NUM_DIGITS(4), .SCAN_DIV(8), .DEAD_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .load(load), .value_in(value_in), .blank_lz(blank_lz),
        .data_out(data_out0), .digit_an(digit_an0), .digit_idx(digit_idx0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // t counts cycles since reset release; slot = t/8 mod 4, tick = t mod 8
    function automatic logic [3:0] exp_an(input logic [15:0] v, input logic bl, input int t, input int dead);
        int idx = (t / 8) % 4;
        int tk  = t % 8;
        if (tk < dead || (bl && idx != 0 && (v >> (4 * idx)) == 16'h0)) return 4'b1111;
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] exp_nib(input logic [15:0] v, input int t);
        logic [15:0] s = v >> (4 * ((t / 8) % 4));
        return s[3:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] ea, ea0;
        rst = 1'b1; load = 1'b0; value_in = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            ea  = (c < 2 || c == 8) ? 4'b1111 : 4'b1110;
            ea0 = (c < 8) ? 4'b1110 : 4'b1101;
            checks += 4;
            if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data c=%0d got %h exp 0", c, data_out); end
            if (digit_idx !== ((c < 8) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL reset_idx c=%0d got %0d", c, digit_idx); end
            if (digit_an !== ea) begin errors++; $display("FAIL reset_an c=%0d got %b exp %b", c, digit_an, ea); end
            if (digit_an0 !== ea0) begin errors++; $display("FAIL reset_an0 c=%0d got %b exp %b", c, digit_an0, ea0); end
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        do_reset();
        value_in = 16'h1A3F; load = 1'b1; blank_lz = 1'b0;
        @(negedge clk);
        load = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            checks += 4;
            if (data_out !== exp_nib(16'h1A3F, t)) begin errors++; $display("FAIL scan_data t=%0d got %h exp %h", t, data_out, exp_nib(16'h1A3F, t)); end
            if (digit_idx !== 2'((t / 8) % 4)) begin errors++; $display("FAIL scan_idx t=%0d got %0d exp %0d", t, digit_idx, (t / 8) % 4); end
            if (digit_an !== exp_an(16'h1A3F, 1'b0, t, 2)) begin errors++; $display("FAIL scan_an t=%0d got %b exp %b", t, digit_an, exp_an(16'h1A3F, 1'b0, t, 2)); end
            if (digit_an0 !== exp_an(16'h1A3F, 1'b0, t, 0)) begin errors++; $display("FAIL scan_an0 t=%0d got %b exp %b", t, digit_an0, exp_an(16'h1A3F, 1'b0, t, 0)); end
            @(negedge clk);
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [4] = '{16'h0050, 16'h0000, 16'h0000, 16'h0F00};
        logic        bls  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            value_in = vals[k]; blank_lz = bls[k]; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            for (int t = 1; t <= 32; t++) begin
                checks += 3;
                if (data_out !== exp_nib(vals[k], t)) begin errors++; $display("FAIL blank_data v=%h t=%0d got %h", vals[k], t, data_out); end
                if (digit_an !== exp_an(vals[k], bls[k], t, 2)) begin errors++; $display("FAIL blank_an v=%h bl=%0d t=%0d got %b exp %b", vals[k], bls[k], t, digit_an, exp_an(vals[k], bls[k], t, 2)); end
                if (digit_an0 !== exp_an(vals[k], bls[k], t, 0)) begin errors++; $display("FAIL blank_an0 v=%h bl=%0d t=%0d got %b exp %b", vals[k], bls[k], t, digit_an0, exp_an(vals[k], bls[k], t, 0)); end
                @(negedge clk);
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_blank_toggle();
        do_reset();
        value_in = 16'h0050; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (18) @(negedge clk);
        checks++;
        if (digit_an !== 4'b1011) begin errors++; $display("FAIL tog_unblanked got %b exp 1011", digit_an); end
        blank_lz = 1'b1;
        @(negedge clk);
        checks++;
        if (digit_an !== 4'b1111) begin errors++; $display("FAIL tog_blanked got %b exp 1111", digit_an); end
        blank_lz = 1'b0;
        @(negedge clk);
        checks++;
        if (digit_an !== 4'b1011) begin errors++; $display("FAIL tog_restored got %b exp 1011", digit_an); end
    endtask

    task automatic test_load_track();
        logic [15:0] vals [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        logic [3:0]  exp  [4] = '{4'h4, 4'h8, 4'hC, 4'h0};
        do_reset();
        load = 1'b1;
        for (int k = 0; k < 4; k++) begin
            value_in = vals[k];
            @(negedge clk);
            checks++;
            if (data_out !== exp[k]) begin errors++; $display("FAIL track k=%0d got %h exp %h", k, data_out, exp[k]); end
        end
        load = 1'b0; value_in = 16'hFFFF;
        @(negedge clk);
        checks++;
        if (data_out !== 4'h0) begin errors++; $display("FAIL track_hold got %h exp 0", data_out); end
    endtask

    task automatic test_load_at_wrap();
        do_reset();
        value_in = 16'h1111; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (data_out !== 4'h1) begin errors++; $display("FAIL wrap_before got %h exp 1", data_out); end
        value_in = 16'h2222; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks += 4;
        if (digit_idx !== 2'd1) begin errors++; $display("FAIL wrap_idx got %0d exp 1", digit_idx); end
        if (data_out !== 4'h2) begin errors++; $display("FAIL wrap_data got %h exp 2", data_out); end
        if (digit_an !== 4'b1111) begin errors++; $display("FAIL wrap_an got %b exp 1111", digit_an); end
        if (digit_an0 !== 4'b1101) begin errors++; $display("FAIL wrap_an0 got %b exp 1101", digit_an0); end
        repeat (2) @(negedge clk);
        checks += 2;
        if (digit_an !== 4'b1101) begin errors++; $display("FAIL wrap_lit got %b exp 1101", digit_an); end
        if (data_out !== 4'h2) begin errors++; $display("FAIL wrap_lit_data got %h exp 2", data_out); end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        value_in = 16'hFFFF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        checks += 2;
        if (digit_idx !== 2'd2) begin errors++; $display("FAIL mid_pre_idx got %0d exp 2", digit_idx); end
        if (digit_an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an got %b exp 1011", digit_an); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (digit_idx !== 2'd0) begin errors++; $display("FAIL mid_idx got %0d exp 0", digit_idx); end
        if (data_out !== 4'h0) begin errors++; $display("FAIL mid_data got %h exp 0", data_out); end
        if (digit_an !== 4'b1111) begin errors++; $display("FAIL mid_an got %b exp 1111", digit_an); end
        if (digit_an0 !== 4'b1110) begin errors++; $display("FAIL mid_an0 got %b exp 1110", digit_an0); end
        repeat (2) @(negedge clk);
        checks++;
        if (digit_an !== 4'b1110) begin errors++; $display("FAIL mid_tick2_an got %b exp 1110", digit_an); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_blank_toggle();
        test_load_track();
        test_load_at_wrap();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
